// File: rtl/fb_pkg.sv
// Shared types and defaults for the double-buffered framebuffer write controller.
// Contents: sequencer state encoding, default geometry, overrun counter width.
package fb_pkg;

  localparam int unsigned NUM_PIXELS_DEF = 307200;
  localparam int unsigned ADDR_W_DEF     = 19;
  localparam int unsigned OVR_W          = 8;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    DRAW    = 2'd1,
    WAIT_VS = 2'd2,
    SWAP    = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_clear_engine.sv
// Back-buffer clear address generator: sweeps 0..NUM_PIXELS-1, one address per cycle.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset (reset leaves the engine running from 0)
//   start_i      - restart the sweep from address 0
//   addr_o       - current clear address (registered)
//   we_o         - sweep active, addr_o is a valid clear write (registered)
//   done_c       - combinational pulse while the final address is being issued
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic              done_c
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              active_q, active_d;

  // Sweep counter; wraps to 0 and idles after the last address
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start_i) begin
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == LAST_ADDR) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign addr_o = cnt_q;
  assign we_o   = active_q;
  assign done_c = active_q && (cnt_q == LAST_ADDR);

endmodule

// File: rtl/fb_swap_ctrl.sv
// Front/back buffer sequencer and back-buffer write-port arbiter for a 1-bpp
// double-buffered framebuffer. Clears the back buffer after every swap, then
// grants the write port to the draw engine; swaps on vsync after draw_done.
// Optional feature macro: FB_OVERRUN_CNT_EN (adds overrun_cnt output).
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   vsync                  - display vertical sync (active-high, clk-synchronous)
//   draw_we/addr/data      - draw engine pixel write request
//   draw_done              - one-cycle pulse, frame drawing complete
//   draw_ready             - draw writes are accepted this cycle
//   wr_en_a / wr_en_b      - per-buffer write enables (only the back buffer strobes)
//   wr_addr / wr_data      - shared write address/data to both buffers
//   front_sel              - 0: A displayed, B drawn; 1: B displayed, A drawn
//   busy_clear             - back-buffer clear in progress
//   overrun_cnt            - (FB_OVERRUN_CNT_EN) saturating count of missed frames
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic              draw_data,
  input  logic              draw_done,
  output logic              draw_ready,
  output logic              wr_en_a,
  output logic              wr_en_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              front_sel,
  output logic              busy_clear
`ifdef FB_OVERRUN_CNT_EN
  ,
  output logic [OVR_W-1:0]  overrun_cnt
`endif
);

  localparam int unsigned ADDR_W1 = ADDR_W + 1;

  fb_state_e         state_q, state_d;
  logic              vsync_q;
  logic              vs_rise_c;
  logic              draw_hit_c;
  logic              do_wr_c;

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;
  logic              clr_done_c;
  logic              clr_start_c;

  logic              draw_ready_q, draw_ready_d;
  logic              wr_en_a_q, wr_en_a_d;
  logic              wr_en_b_q, wr_en_b_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_data_q, wr_data_d;
  logic              front_sel_q, front_sel_d;
  logic              busy_clear_q, busy_clear_d;

  assign vs_rise_c   = vsync & ~vsync_q;
  assign clr_start_c = (state_q == SWAP);
  // Zero-extended compare so an address space exactly NUM_PIXELS deep still works
  assign draw_hit_c  = draw_we && ({1'b0, draw_addr} < ADDR_W1'(NUM_PIXELS));

  fb_clear_engine #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_clear (
    .clk     (clk),
    .reset   (reset),
    .start_i (clr_start_c),
    .addr_o  (clr_addr),
    .we_o    (clr_we),
    .done_c  (clr_done_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a vsync edge only counts once we are already waiting
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_done_c) state_d = DRAW;
      DRAW:    if (draw_done)  state_d = WAIT_VS;
      WAIT_VS: if (vs_rise_c)  state_d = SWAP;
      SWAP:    state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // Output next-values; the write strobe is steered to whichever buffer is back
  always_comb begin
    do_wr_c      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    front_sel_d  = front_sel_q;
    case (state_q)
      CLEAR: begin
        if (clr_we) begin
          do_wr_c   = 1'b1;
          wr_addr_d = clr_addr;
          wr_data_d = 1'b0;
        end
      end
      DRAW: begin
        if (draw_hit_c) begin
          do_wr_c   = 1'b1;
          wr_addr_d = draw_addr;
          wr_data_d = draw_data;
        end
      end
      SWAP:    front_sel_d = ~front_sel_q;
      default: ;
    endcase
    wr_en_a_d    = do_wr_c & front_sel_q;
    wr_en_b_d    = do_wr_c & ~front_sel_q;
    draw_ready_d = (state_d == DRAW);
    busy_clear_d = (state_d == CLEAR);
  end

  // Output and vsync-history registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q      <= 1'b0;
      draw_ready_q <= 1'b0;
      wr_en_a_q    <= 1'b0;
      wr_en_b_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 1'b0;
      front_sel_q  <= 1'b0;
      busy_clear_q <= 1'b1;
    end else begin
      vsync_q      <= vsync;
      draw_ready_q <= draw_ready_d;
      wr_en_a_q    <= wr_en_a_d;
      wr_en_b_q    <= wr_en_b_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      front_sel_q  <= front_sel_d;
      busy_clear_q <= busy_clear_d;
    end
  end

  assign draw_ready = draw_ready_q;
  assign wr_en_a    = wr_en_a_q;
  assign wr_en_b    = wr_en_b_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign front_sel  = front_sel_q;
  assign busy_clear = busy_clear_q;

`ifdef FB_OVERRUN_CNT_EN
  logic [OVR_W-1:0] ovr_q, ovr_d;

  // A vsync edge before the frame is finished means the display missed a frame
  always_comb begin
    ovr_d = ovr_q;
    if (vs_rise_c && (state_q == CLEAR || state_q == DRAW) && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Self-checking bench for fb_swap_ctrl with a reduced frame size.
module tb_fb_swap_ctrl;

  localparam int unsigned N  = 600;
  localparam int unsigned AW = 10;
`ifdef FB_OVERRUN_CNT_EN
  localparam int unsigned VW = AW + 6 + 8;
`else
  localparam int unsigned VW = AW + 6;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b0;
  logic          draw_we = 1'b0;
  logic [AW-1:0] draw_addr = '0;
  logic          draw_data = 1'b0;
  logic          draw_done = 1'b0;
  logic          draw_ready, wr_en_a, wr_en_b, wr_data, front_sel, busy_clear;
  logic [AW-1:0] wr_addr;
`ifdef FB_OVERRUN_CNT_EN
  logic [7:0]    overrun_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fb_swap_ctrl #(.NUM_PIXELS(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .draw_we    (draw_we),
    .draw_addr  (draw_addr),
    .draw_data  (draw_data),
    .draw_done  (draw_done),
    .draw_ready (draw_ready),
    .wr_en_a    (wr_en_a),
    .wr_en_b    (wr_en_b),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .front_sel  (front_sel),
    .busy_clear (busy_clear)
`ifdef FB_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  // Behavioural reference: pixels left to clear, drawing/waiting/swap-pending flags
  int            m_clear_left;
  logic          m_drawing, m_waiting, m_swapping, m_front, m_vs_prev;
  logic          e_en_a, e_en_b, e_data, e_ready, e_busy;
  logic [AW-1:0] e_addr;
  int            e_ovr;

  function automatic void model_reset();
    m_clear_left = N;
    m_drawing = 0; m_waiting = 0; m_swapping = 0; m_front = 0; m_vs_prev = 0;
    e_en_a = 0; e_en_b = 0; e_data = 0; e_ready = 0; e_busy = 1; e_addr = '0; e_ovr = 0;
  endfunction

  function automatic void model_write(logic [AW-1:0] a, logic d);
    if (m_front) e_en_a = 1; else e_en_b = 1;
    e_addr = a;
    e_data = d;
  endfunction

  function automatic void model_step();
    logic rise;
    logic unfinished;
    rise = vsync && !m_vs_prev;
    unfinished = (m_clear_left > 0) || m_drawing;
    m_vs_prev = vsync;
    e_en_a = 0;
    e_en_b = 0;
    if (m_clear_left > 0) begin
      model_write(AW'(N - m_clear_left), 1'b0);
      m_clear_left--;
      if (m_clear_left == 0) m_drawing = 1;
    end else if (m_drawing) begin
      if (draw_we && int'(draw_addr) < int'(N)) model_write(draw_addr, draw_data);
      if (draw_done) begin m_drawing = 0; m_waiting = 1; end
    end else if (m_waiting) begin
      if (rise) begin m_waiting = 0; m_swapping = 1; end
    end else if (m_swapping) begin
      m_swapping = 0;
      m_front = !m_front;
      m_clear_left = N;
    end
    if (rise && unfinished && e_ovr < 255) e_ovr++;
    e_ready = m_drawing;
    e_busy = (m_clear_left > 0);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
`ifdef FB_OVERRUN_CNT_EN
    return {e_ready, e_en_a, e_en_b, e_addr, e_data, m_front, e_busy, 8'(e_ovr)};
`else
    return {e_ready, e_en_a, e_en_b, e_addr, e_data, m_front, e_busy};
`endif
  endfunction

  function automatic logic [VW-1:0] dut_vec();
`ifdef FB_OVERRUN_CNT_EN
    return {draw_ready, wr_en_a, wr_en_b, wr_addr, wr_data, front_sel, busy_clear, overrun_cnt};
`else
    return {draw_ready, wr_en_a, wr_en_b, wr_addr, wr_data, front_sel, busy_clear};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #3 reset = 0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", dut_vec(), exp_vec());
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_clear();
    int n_wr = 0;
    draw_we = 1; draw_data = 1; draw_addr = AW'($urandom_range(0, N - 1));
    for (int i = 0; i < int'(N) + 4 && m_clear_left > 0; i++) begin
      tick();
      draw_addr = AW'($urandom_range(0, N - 1));
      if (wr_en_b === 1'b1) n_wr++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL clear_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (n_wr !== int'(N) || draw_ready !== 1'b1) begin
      n_bad++; $display("FAIL clear_total: got writes=%0d ready=%b want writes=%0d ready=1", n_wr, draw_ready, N);
    end
    draw_we = 0;
  endtask

  task automatic test_draw();
    int st_addr[7] = '{100, int'(N), 1023, 5, 0, int'(N) - 1, 37};
    logic st_we[7] = '{1, 1, 1, 0, 1, 1, 1};
    logic st_d[7] = '{1, 1, 1, 1, 1, 1, 0};
    for (int k = 0; k < 7; k++) begin
      draw_we = st_we[k]; draw_addr = AW'(st_addr[k]); draw_data = st_d[k];
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL draw_item%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (k == 0) begin
        n_cmp++;
        if ({wr_en_b, wr_addr, wr_data} !== {1'b1, AW'(100), 1'b1}) begin
          n_bad++; $display("FAIL draw_addr100: got en=%b addr=%0d data=%b want en=1 addr=100 data=1", wr_en_b, wr_addr, wr_data);
        end
      end
      if (k == 1 || k == 2) begin
        n_cmp++;
        if ({wr_en_a, wr_en_b} !== 2'b00) begin
          n_bad++; $display("FAIL draw_out_of_range%0d: got en_a=%b en_b=%b want 0 0", k, wr_en_a, wr_en_b);
        end
      end
    end
    for (int i = 0; i < 100; i++) begin
      draw_we = 1'($urandom); draw_addr = AW'($urandom_range(0, 1023)); draw_data = 1'($urandom);
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL draw_rand%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    draw_we = 0;
  endtask

  task automatic test_swap();
    int n_a = 0;
    int n_b = 0;
    draw_done = 1;
    tick();
    draw_done = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL swap_wait%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    vsync = 1;
    tick();
    n_cmp++;
    if (front_sel !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL swap_enter: got front=%b vec=%h want front=0 vec=%h", front_sel, dut_vec(), exp_vec());
    end
    tick();
    n_cmp++;
    if (front_sel !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL swap_toggle: got front=%b vec=%h want front=1 vec=%h", front_sel, dut_vec(), exp_vec());
    end
    vsync = 0;
    // Run the new clear half-way so the mid-clear reset test can interrupt it
    while (m_clear_left > int'(N / 2)) begin
      tick();
      if (wr_en_a === 1'b1) n_a++;
      if (wr_en_b === 1'b1) n_b++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL swap_clear: got %h want %h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (n_a !== int'(N / 2) || n_b !== 0) begin
      n_bad++; $display("FAIL swap_clear_buffer: got a=%0d b=%0d want a=%0d b=0", n_a, n_b, N / 2);
    end
  endtask

  task automatic test_reset_mid_clear();
    #2 reset = 0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL midreset_values: got %h want %h", dut_vec(), exp_vec());
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    tick();
    n_cmp++;
    if ({wr_en_b, wr_en_a, wr_addr, front_sel} !== {2'b10, AW'(0), 1'b0}) begin
      n_bad++; $display("FAIL midreset_restart: got en_b=%b en_a=%b addr=%0d front=%b want 1 0 0 0", wr_en_b, wr_en_a, wr_addr, front_sel);
    end
    while (m_clear_left > 0) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL midreset_clear: got %h want %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_done_with_vsync();
    vsync = 0;
    tick();
    draw_done = 1; vsync = 1;
    tick();
    draw_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL dv_hold%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (front_sel !== 1'b0) begin
      n_bad++; $display("FAIL dv_no_swap: got front=%b want 0", front_sel);
    end
    vsync = 0;
    tick();
    vsync = 1;
    tick();
    tick();
    n_cmp++;
    if (front_sel !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL dv_next_swap: got front=%b vec=%h want front=1 vec=%h", front_sel, dut_vec(), exp_vec());
    end
    vsync = 0;
  endtask

  task automatic test_random();
    int vs_gap = 120;
    int vs_ph = 0;
    for (int i = 0; i < 3000; i++) begin
      vsync = (vs_ph < 3);
      vs_ph++;
      if (vs_ph >= vs_gap) begin vs_ph = 0; vs_gap = $urandom_range(60, 900); end
      draw_we = 1'($urandom); draw_addr = AW'($urandom_range(0, 1023)); draw_data = 1'($urandom);
      draw_done = ($urandom_range(0, 39) == 0);
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL rand%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    vsync = 0; draw_we = 0; draw_done = 0;
  endtask

`ifdef FB_OVERRUN_CNT_EN
  task automatic test_overrun();
    vsync = 0;
    reset = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    while (m_clear_left > 0) tick();
    for (int i = 0; i < 3; i++) begin
      vsync = 1; tick(); vsync = 0; tick();
    end
    n_cmp++;
    if (overrun_cnt !== 8'd3) begin
      n_bad++; $display("FAIL overrun_3: got %0d want 3", overrun_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      vsync = 1; tick(); vsync = 0; tick();
    end
    n_cmp++;
    if (overrun_cnt !== 8'd255 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL overrun_sat: got %0d want 255", overrun_cnt);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_draw();
    test_swap();
    test_reset_mid_clear();
    test_done_with_vsync();
    test_random();
`ifdef FB_OVERRUN_CNT_EN
    test_overrun();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
- Sequencer and write-port arbiter for the double-buffered 640x480 1-bpp framebuffer.
- Owns front/back buffer selection and swaps buffers on vertical sync after the draw engine finishes a frame.
- Clears the new back buffer after every swap, then grants the back-buffer write port to the draw engine.
- Sits between the draw engine and the two frame RAM write ports; the display reader follows front_sel.

Parameters:
- NUM_PIXELS, 307200, pixels per buffer; clear covers addresses 0..NUM_PIXELS-1.
- ADDR_W, 19, address width; must satisfy 2**ADDR_W >= NUM_PIXELS.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- vsync  input  1  display vertical sync, synchronous to clk, active-high
- draw_we  input  1  draw engine pixel write request
- draw_addr  input  ADDR_W  draw write address
- draw_data  input  1  draw write pixel value
- draw_done  input  1  single-cycle pulse: frame drawing complete
- draw_ready  output  1  draw writes accepted this cycle
- wr_en_a  output  1  write enable, buffer A
- wr_en_b  output  1  write enable, buffer B
- wr_addr  output  ADDR_W  shared write address to both buffers
- wr_data  output  1  shared write data
- front_sel  output  1  0: A is front (displayed) and B is back; 1: B is front
- busy_clear  output  1  high while the back-buffer clear is in progress

Behaviour:
- Reset (reset=0, asynchronous): state CLEAR, clear counter=0, front_sel=0, draw_ready=0, wr_en_a=0, wr_en_b=0, wr_addr=0, wr_data=0, busy_clear=1, vsync_q=0.
- All outputs are registered. Write latency is 1 cycle from an accepted draw_we, or from a clear counter value, to wr_en/wr_addr/wr_data.
- Back-buffer enable: wr_en_b is the active strobe when front_sel=0; wr_en_a when front_sel=1. The front-buffer enable is always 0.
- vsync edge: vs_rise = vsync & ~vsync_q; vsync_q is registered every cycle.
- CLEAR:
  - Issues one write per cycle to the back buffer with data 0 at counter values 0..NUM_PIXELS-1. Exactly NUM_PIXELS writes, no extra write.
  - On the cycle the counter issues NUM_PIXELS-1, the next state is DRAW.
  - busy_clear=1 and draw_ready=0 throughout.
  - Draw requests are ignored, not queued.
- DRAW:
  - draw_ready=1.
  - draw_we=1 with draw_addr<NUM_PIXELS produces a back-buffer write of draw_data at draw_addr.
  - draw_addr>=NUM_PIXELS: write suppressed silently.
  - draw_done=1 moves to WAIT_VS. A draw_we in the same cycle is still performed.
- WAIT_VS:
  - draw_ready=0, no writes.
  - Only a vs_rise that occurs while in WAIT_VS moves to SWAP. An edge in the same cycle as draw_done belongs to DRAW and does not count.
- SWAP: one cycle; front_sel toggles, counter=0, next state CLEAR.
- draw_done outside DRAW: ignored.
- Reset mid-operation: immediate return to reset values. front_sel returns to 0 and the clear restarts from address 0.
- Counter width: ADDR_W bits; it never exceeds NUM_PIXELS-1.

Optional Feature:
- Macro: FB_OVERRUN_CNT_EN.
- Defined:
  - Adds output overrun_cnt[7:0], reset 0.
  - Increments by 1 on each vs_rise while the state is CLEAR or DRAW, i.e. a frame was missed.
  - Saturates at 255.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fb_pkg:
  - state enum {CLEAR, DRAW, WAIT_VS, SWAP}, 2-bit encoding
  - NUM_PIXELS_DEF=307200
  - ADDR_W_DEF=19
- Sub-module fb_clear_engine:
  - Inputs: clk, reset, start, NUM_PIXELS parameter.
  - Outputs: addr, we, done pulse.
  - fb_swap_ctrl muxes its write against the draw path.

Test Plan:
- Release reset, hold draw_we=1 -> busy_clear=1 and wr_en_b pulses exactly 307200 cycles with addresses 0..307199 and data 0; wr_en_a=0; draw_ready rises the cycle after the last clear write; no draw writes during the clear.
- In DRAW, draw_we=1, addr=1000, data=1 -> next cycle wr_en_b=1, wr_addr=1000, wr_data=1; addr=307200 -> no write.
- draw_done pulse, vsync rise 50 cycles later -> front_sel 0->1 one cycle after SWAP; the following clear drives wr_en_a only.
- draw_done and a vsync rise in the same cycle -> no swap; the swap occurs on the next vsync rise.
- Assert reset at clear address 150000 -> outputs return to reset values; after release the clear restarts at 0 with front_sel=0.
- With FB_OVERRUN_CNT_EN, 3 vsync rises during DRAW -> overrun_cnt=3; 300 rises -> overrun_cnt=255.
